// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the five-stage pipeline stall control.
//   stall_state_e      : memory-wait FSM states (RUN, MEM_WAIT).
//   DEFAULT_WAIT_LIMIT : default cycle budget for one SRAM access.
//   IDEX_NOP_*         : field values loaded into ID/EX when a bubble is inserted.
package pipeline_stall_controller_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } stall_state_e;

  localparam int DEFAULT_WAIT_LIMIT = 64;

  // A bubble is an ID/EX entry with every side-effect enable cleared.
  localparam logic [3:0] IDEX_NOP_EXE_CMD  = 4'b0000;
  localparam logic       IDEX_NOP_WB_EN    = 1'b0;
  localparam logic       IDEX_NOP_MEM_R_EN = 1'b0;
  localparam logic       IDEX_NOP_MEM_W_EN = 1'b0;
  localparam logic       IDEX_NOP_B        = 1'b0;
  localparam logic       IDEX_NOP_S        = 1'b0;

endpackage

// File: rtl/pipeline_stall_controller_perf_cnt.sv
// stall_perf_counter: one saturating event counter.
//   clk, rst  : clock and asynchronous active-high reset.
//   inc_i     : count one event this cycle.
//   clear_i   : synchronous clear (has priority over inc_i).
//   cnt_o     : current count; holds at all-ones instead of wrapping.
module stall_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: turns ID hazards, EXE branch flushes and MEM-stage
// SRAM waits into one consistent set of pipeline-register controls per cycle.
// Optional feature macro: STALL_PERF_CNT_EN (adds three saturating counters).
//   clk, rst        : clock, asynchronous active-high reset.
//   hazard_detected : RAW hazard on the ID instruction.
//   branch_taken    : EXE branch resolved taken.
//   mem_req         : MEM instruction is a load/store.
//   mem_ready       : SRAM access complete (pulse).
//   sram_start      : one-cycle pulse launching the SRAM access.
//   pc_freeze, ifid_freeze, ifid_flush, idex_bubble, back_freeze : register controls.
//   mem_timeout     : sticky flag, an access was abandoned.
//   hazard_stall_cnt, mem_stall_cnt, flush_cnt : perf counters (macro only).
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             sram_start,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             back_freeze,
  output logic             mem_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] hazard_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [WCNT_W-1:0] LIMIT = WCNT_W'(WAIT_LIMIT);

  if (WAIT_LIMIT < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipeline_stall_controller: WAIT_LIMIT and CNT_W must be >= 1");
  end

  stall_state_e      state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              timeout_q, timeout_d;
  logic              mem_freeze;
  logic              start_c;
  logic              branch_act;
  logic              hazard_act;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    timeout_d  = timeout_q;
    start_c    = 1'b0;
    mem_freeze = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req) begin
          start_c = 1'b1;
          // Zero-wait SRAM completes in the launch cycle: no stall at all.
          if (!mem_ready) begin
            mem_freeze = 1'b1;
            state_d    = MEM_WAIT;
            wcnt_d     = WCNT_W'(1);
          end
        end
      end
      MEM_WAIT: begin
        // Completion wins over a coincident timeout; either way the freeze
        // releases in this same cycle so the pipeline advances.
        if (mem_ready) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q >= LIMIT) begin
          timeout_d = 1'b1;
          state_d   = RUN;
          wcnt_d    = '0;
        end else begin
          mem_freeze = 1'b1;
          if (wcnt_q != {WCNT_W{1'b1}}) begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  // A memory freeze holds the EXE and ID instructions in place, so branch and
  // hazard are only acted on once the freeze is released. A taken branch makes
  // the ID instruction wrong-path, so it overrides any hazard on it.
  assign branch_act = !mem_freeze && branch_taken;
  assign hazard_act = !mem_freeze && hazard_detected && !branch_taken;

  // Outputs are gated by rst so an asynchronous reset releases them at once,
  // even while the inputs still request a stall.
  assign sram_start  = !rst && start_c;
  assign pc_freeze   = !rst && (mem_freeze || hazard_act);
  assign ifid_freeze = !rst && (mem_freeze || hazard_act);
  assign ifid_flush  = !rst && branch_act;
  assign idex_bubble = !rst && (branch_act || hazard_act);
  assign back_freeze = !rst && mem_freeze;
  assign mem_timeout = timeout_q;

`ifdef STALL_PERF_CNT_EN
  stall_perf_counter #(.CNT_W(CNT_W)) u_hazard_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (!rst && hazard_act),
    .clear_i (1'b0),
    .cnt_o   (hazard_stall_cnt)
  );

  stall_perf_counter #(.CNT_W(CNT_W)) u_mem_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (back_freeze),
    .clear_i (1'b0),
    .cnt_o   (mem_stall_cnt)
  );

  stall_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (ifid_flush),
    .clear_i (1'b0),
    .cnt_o   (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (WAIT_LIMIT = 4).
module tb_pipeline_stall_controller;

  localparam int CNT_W = 32;

  logic clk;
  logic rst;
  logic hazard_detected, branch_taken, mem_req, mem_ready;
  logic sram_start, pc_freeze, ifid_freeze, ifid_flush, idex_bubble, back_freeze, mem_timeout;
`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] hazard_stall_cnt, mem_stall_cnt, flush_cnt;
`endif

  pipeline_stall_controller #(
    .WAIT_LIMIT (4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .sram_start      (sram_start),
    .pc_freeze       (pc_freeze),
    .ifid_freeze     (ifid_freeze),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .back_freeze     (back_freeze),
    .mem_timeout     (mem_timeout)
`ifdef STALL_PERF_CNT_EN
    ,
    .hazard_stall_cnt(hazard_stall_cnt),
    .mem_stall_cnt   (mem_stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in  = {hazard, branch, mem_req, mem_ready}
  // exp = {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, back_freeze, sram_start, mem_timeout}
  typedef struct packed {
    logic [3:0] in;
    logic [6:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] outs();
    return {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, back_freeze, sram_start, mem_timeout};
  endfunction

  task automatic drive(input logic [3:0] in);
    {hazard_detected, branch_taken, mem_req, mem_ready} = in;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One pipeline cycle: drive at the falling edge, sample shortly after.
  task automatic cycle(input string name, input logic [3:0] in, input logic [6:0] exp);
    @(negedge clk);
    drive(in);
    #1;
    check(name, exp);
  endtask

  vec_t vecs[16];
  vec_t tmo[8];

  initial begin
    vecs[0]  = {4'b1000, 7'b1101000}; // hazard cycle 1
    vecs[1]  = {4'b1000, 7'b1101000}; // hazard cycle 2
    vecs[2]  = {4'b0000, 7'b0000000}; // hazard gone
    vecs[3]  = {4'b1100, 7'b0011000}; // branch beats hazard
    vecs[4]  = {4'b0100, 7'b0011000}; // branch only
    vecs[5]  = {4'b0011, 7'b0000010}; // zero-wait SRAM
    vecs[6]  = {4'b1011, 7'b1101010}; // zero-wait SRAM with hazard
    vecs[7]  = {4'b0010, 7'b1100110}; // SRAM cycle 1: launch + freeze
    vecs[8]  = {4'b0010, 7'b1100100}; // SRAM cycle 2
    vecs[9]  = {4'b1110, 7'b1100100}; // SRAM cycle 3: hazard/branch ignored
    vecs[10] = {4'b0011, 7'b0000000}; // SRAM cycle 4: ready, freeze drops
    vecs[11] = {4'b0000, 7'b0000000}; // back in RUN
    vecs[12] = {4'b0010, 7'b1100110}; // new access launch
    vecs[13] = {4'b0111, 7'b0011000}; // release cycle re-evaluates branch
    vecs[14] = {4'b0000, 7'b0000000}; // idle
    vecs[15] = {4'b1000, 7'b1101000}; // hazard still works afterwards

    tmo[0] = {4'b0010, 7'b1100110};   // launch
    tmo[1] = {4'b0010, 7'b1100100};   // wait cnt 1
    tmo[2] = {4'b0010, 7'b1100100};   // wait cnt 2
    tmo[3] = {4'b0010, 7'b1100100};   // wait cnt 3
    tmo[4] = {4'b0010, 7'b0000000};   // cnt hits limit: abandon, freeze drops
    tmo[5] = {4'b0000, 7'b0000001};   // sticky timeout visible
    tmo[6] = {4'b1000, 7'b1101001};   // hazard, timeout still set
    tmo[7] = {4'b0011, 7'b0000011};   // zero-wait, timeout still set

    rst = 1'b1;
    drive(4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_idle", 7'b0000000);
    drive(4'b0010);
    #1;
    check("reset_gates_req", 7'b0000000);
`ifdef STALL_PERF_CNT_EN
    checks++;
    if ({hazard_stall_cnt, mem_stall_cnt, flush_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0",
               hazard_stall_cnt, mem_stall_cnt, flush_cnt);
    end
`endif
    @(negedge clk);
    drive(4'b0000);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);
    end

    for (int i = 0; i < 8; i++) begin
      cycle($sformatf("timeout%0d", i), tmo[i].in, tmo[i].exp);
    end

    // Asynchronous reset in the middle of a MEM_WAIT.
    cycle("arst_launch", 4'b0010, 7'b1100111);
    cycle("arst_wait", 4'b0010, 7'b1100101);
    #1;
    rst = 1'b1;
    #1;
    check("arst_immediate", 7'b0000000);
`ifdef STALL_PERF_CNT_EN
    checks++;
    if ({hazard_stall_cnt, mem_stall_cnt, flush_cnt} !== '0) begin
      errors++;
      $display("FAIL arst_cnt: got %0d/%0d/%0d expected 0/0/0",
               hazard_stall_cnt, mem_stall_cnt, flush_cnt);
    end
`endif
    @(negedge clk);
    drive(4'b0000);
    rst = 1'b0;
    #1;
    check("arst_state_run", 7'b0000000);
    cycle("arst_after", 4'b0000, 7'b0000000);
    cycle("arst_zero_wait", 4'b0011, 7'b0000010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
